// File: rtl/snitch_clint_pkg.sv
// Shared constants, register-bus payload types and helpers for the Snitch cluster CLINT.
package snitch_clint_pkg;

  localparam int unsigned AddrWidth    = 16;
  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

  localparam logic [AddrWidth-1:0] MsipBase     = 16'h0000;
  localparam logic [AddrWidth-1:0] MtimecmpBase = 16'h4000;
  localparam logic [AddrWidth-1:0] MtimeOffset  = 16'hBFF8;

  localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

  // Bus payloads are sized for the widest lane; narrower buses use the low bits.
  typedef struct packed {
    logic [AddrWidth-1:0]    addr;
    logic                    write;
    logic [MaxDataWidth-1:0] wdata;
    logic [MaxStrbWidth-1:0] strb;
  } reg_req_t;

  typedef struct packed {
    logic [MaxDataWidth-1:0] rdata;
    logic                    error;
  } reg_rsp_t;

  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] mask;
    for (int i = 0; i < 8; i++) mask[8*i +: 8] = {8{strb[i]}};
    return mask;
  endfunction

  function automatic logic [63:0] merge64(input logic [63:0] old_val,
                                          input logic [63:0] new_val,
                                          input logic [63:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/snitch_clint_timer.sv
// Prescaled 64-bit mtime counter; a bus write to mtime takes priority over an increment.
module snitch_clint_timer #(
  parameter int unsigned Prescale = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        wr_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] wmask_i,
  output logic [63:0] mtime_o
);
  import snitch_clint_pkg::*;

  localparam int unsigned PsWidth = (Prescale > 1) ? $clog2(Prescale) : 1;
  localparam logic [PsWidth-1:0] PsMax = PsWidth'(Prescale - 1);

  logic [PsWidth-1:0] ps_q, ps_d;
  logic [63:0]        mtime_q, mtime_d;
  logic               wrap;

  // Prescaler keeps counting ticks even when a write suppresses the increment.
  always_comb begin
    ps_d    = ps_q;
    wrap    = 1'b0;
    mtime_d = mtime_q;
    if (tick_i) begin
      if (ps_q == PsMax) begin
        ps_d = '0;
        wrap = 1'b1;
      end else begin
        ps_d = ps_q + PsWidth'(1);
      end
    end
    if (wr_i) begin
      mtime_d = merge64(mtime_q, wdata_i, wmask_i);
    end else if (wrap) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ps_q    <= '0;
      mtime_q <= '0;
    end else begin
      ps_q    <= ps_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/snitch_cluster_clint.sv
// Core-local interruptor: memory-mapped msip/mtimecmp/mtime driving per-core msip/mtip.
module snitch_cluster_clint #(
  parameter int unsigned NrCores   = 9,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Prescale  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rtc_tick_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [15:0]            req_addr_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic [NrCores-1:0]     msip_o,
  output logic [NrCores-1:0]     mtip_o
);
  import snitch_clint_pkg::*;

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [15:0] AlignMask = 16'(StrbWidth - 1);

  reg_req_t             req;
  reg_rsp_t             rsp_q, rsp_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [NrCores-1:0]   msip_q, msip_d;
  logic [NrCores-1:0]   mtip_q, mtip_d;
  logic [63:0]          mtimecmp_q [NrCores];
  logic [63:0]          mtimecmp_d [NrCores];
  logic [63:0]          mtime;

  logic [63:0]          wdata_pos;
  logic [7:0]           strb_pos;
  logic [63:0]          rdata_pos;
  logic [DataWidth-1:0] rdata_bus;
  logic [63:0]          wmask;
  logic [NrCores-1:0]   msip_sel, cmp_sel;
  logic                 mtime_sel, hit, lane, msip_aligned, wide_aligned;
  logic                 fire, wr, mtime_wr;

  // Place bus lanes onto a 64-bit register view; a 32-bit bus uses addr[2] as the half select.
  if (DataWidth == 64) begin : gen_dw64
    assign wdata_pos = req_wdata_i;
    assign strb_pos  = req_strb_i;
    assign rdata_bus = rdata_pos;
  end else begin : gen_dw32
    assign wdata_pos = {2{req_wdata_i}};
    assign strb_pos  = req_addr_i[2] ? {req_strb_i, 4'b0000} : {4'b0000, req_strb_i};
    assign rdata_bus = req_addr_i[2] ? rdata_pos[63:32] : rdata_pos[31:0];
  end

  assign req.addr  = req_addr_i;
  assign req.write = req_write_i;
  assign req.wdata = wdata_pos;
  assign req.strb  = strb_pos;

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign fire        = req_valid_i && req_ready_o;
  assign wr          = fire && req.write;

  // Address decode and read mux.
  always_comb begin
    lane         = req.addr[2];
    msip_aligned = (req.addr[1:0] == 2'b00);
    wide_aligned = ((req.addr & AlignMask) == 16'h0000);
    rdata_pos    = '0;
    for (int i = 0; i < NrCores; i++) begin
      msip_sel[i] = msip_aligned && (req.addr[15:2] == 14'((MsipBase >> 2) + 16'(i)));
      cmp_sel[i]  = wide_aligned && (req.addr[15:3] == 13'((MtimecmpBase >> 3) + 16'(i)));
      if (msip_sel[i]) begin
        if (lane) rdata_pos[32] = msip_q[i];
        else      rdata_pos[0]  = msip_q[i];
      end
      if (cmp_sel[i]) rdata_pos = mtimecmp_q[i];
    end
    mtime_sel = wide_aligned && (req.addr[15:3] == MtimeOffset[15:3]);
    if (mtime_sel) rdata_pos = mtime;
    hit = (|msip_sel) || (|cmp_sel) || mtime_sel;
  end

  // Register writes, timer compare and response next-state.
  always_comb begin
    wmask       = strb_to_mask(req.strb);
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    mtime_wr    = wr && mtime_sel;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    for (int i = 0; i < NrCores; i++) begin
      if (wr && msip_sel[i] && req.strb[{lane, 2'b00}]) msip_d[i] = req.wdata[{lane, 5'b00000}];
      if (wr && cmp_sel[i]) mtimecmp_d[i] = merge64(mtimecmp_q[i], req.wdata, wmask);
      mtip_d[i] = (mtime >= mtimecmp_q[i]);
    end
    if (fire) begin
      rsp_valid_d = 1'b1;
      rsp_d.error = !hit;
      rsp_d.rdata = (hit && !req.write) ? 64'(rdata_bus) : 64'd0;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
      rsp_d       = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      msip_q      <= '0;
      mtip_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      for (int i = 0; i < NrCores; i++) mtimecmp_q[i] <= MtimecmpReset;
    end else begin
      msip_q      <= msip_d;
      mtip_q      <= mtip_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      for (int i = 0; i < NrCores; i++) mtimecmp_q[i] <= mtimecmp_d[i];
    end
  end

  snitch_clint_timer #(
    .Prescale (Prescale)
  ) i_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tick_i  (rtc_tick_i),
    .wr_i    (mtime_wr),
    .wdata_i (req.wdata),
    .wmask_i (wmask),
    .mtime_o (mtime)
  );

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_q.rdata[DataWidth-1:0];
  assign rsp_error_o = rsp_q.error;
  assign msip_o      = msip_q;
  assign mtip_o      = mtip_q;

endmodule

// File: tb/tb_snitch_cluster_clint.sv
// Scoreboard bench for snitch_cluster_clint on a 32-bit bus with a prescaler of 4.
module tb_snitch_cluster_clint;

  localparam int unsigned NrCores   = 9;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned Prescale  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rtc_tick;
  logic                 req_valid, req_ready, req_write;
  logic [15:0]          req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic [3:0]           req_strb;
  logic                 rsp_valid, rsp_ready, rsp_err;
  logic [DataWidth-1:0] rsp_rdata;
  logic [NrCores-1:0]   msip, mtip;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  snitch_cluster_clint #(
    .NrCores   (NrCores),
    .DataWidth (DataWidth),
    .Prescale  (Prescale)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rtc_tick_i  (rtc_tick),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_strb_i  (req_strb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_error_o (rsp_err),
    .msip_o      (msip),
    .mtip_o      (mtip)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: pop one expectation per completed response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [32:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, 64'({rsp_err, rsp_rdata}), 64'(e));
      end
    end
  end

  task automatic bus(input string tag, input logic wr, input logic [15:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [31:0] exp_rdata, input logic exp_err, input logic tick);
    bit ok;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    rtc_tick  = tick;
    exp_q.push_back({exp_err, exp_rdata});
    tag_q.push_back(tag);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
      rtc_tick = 1'b0;
    end
    req_valid = 1'b0;
    if (!ok) check_eq({tag, "_accept_timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic wr32(input string tag, input logic [15:0] addr, input logic [31:0] data);
    bus(tag, 1'b1, addr, data, 4'hF, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd32(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    bus(tag, 1'b0, addr, 32'h0, 4'h0, exp, 1'b0, 1'b0);
  endtask

  task automatic rd_err(input string tag, input logic [15:0] addr);
    bus(tag, 1'b0, addr, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      rtc_tick = 1'b1;
      @(posedge clk);
      #1;
      rtc_tick = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check_eq({tag, "_rsp_error"}, 64'(rsp_err), 64'd0);
    check_eq({tag, "_msip"}, 64'(msip), 64'd0);
    check_eq({tag, "_mtip"}, 64'(mtip), 64'd0);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    rtc_tick  = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset while a response is pending.
    wr32("msip0_set", 16'h0000, 32'h1);
    wr32("cmp1_lo", 16'h4008, 32'h0);
    wr32("cmp1_hi", 16'h400C, 32'h0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rd32("rst_dropped", 16'hBFF8, 32'h0);
    check_eq("pre_rst_msip", 64'(msip), 64'h001);
    check_eq("pre_rst_mtip", 64'(mtip), 64'h002);
    check_eq("pre_rst_pending", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("post_rst");
    rd32("mtime_lo_rst", 16'hBFF8, 32'h0);
    rd32("mtime_hi_rst", 16'hBFFC, 32'h0);
    rd32("cmp1_lo_rst", 16'h4008, 32'hFFFF_FFFF);
    rd32("cmp1_hi_rst", 16'h400C, 32'hFFFF_FFFF);

    // msip set/clear; only bit 0 is stored.
    wr32("msip3_set", 16'h000C, 32'h1);
    check_eq("msip3_on", 64'(msip), 64'h008);
    rd32("msip3_rd1", 16'h000C, 32'h1);
    wr32("msip3_clr", 16'h000C, 32'hFFFF_FFFE);
    check_eq("msip3_off", 64'(msip), 64'h000);
    rd32("msip3_rd0", 16'h000C, 32'h0);
    wr32("msip8_all", 16'h0020, 32'hFFFF_FFFF);
    check_eq("msip8_on", 64'(msip), 64'h100);
    rd32("msip8_rd", 16'h0020, 32'h1);
    wr32("msip8_clr", 16'h0020, 32'h0);

    // Prescaled timer reaching mtimecmp[0].
    wr32("cmp0_lo", 16'h4000, 32'h3);
    wr32("cmp0_hi", 16'h4004, 32'h0);
    tick(11);
    check_eq("mtip_before", 64'(mtip), 64'h000);
    rd32("mtime_after11", 16'hBFF8, 32'h2);
    tick(1);
    check_eq("mtip_edge", 64'(mtip), 64'h000);
    @(posedge clk);
    #1;
    check_eq("mtip_rise", 64'(mtip), 64'h001);
    rd32("mtime_is3", 16'hBFF8, 32'h3);

    // mtime wraparound.
    wr32("cmp1_lo0", 16'h4008, 32'h0);
    wr32("cmp1_hi0", 16'h400C, 32'h0);
    wr32("cmp2_lo", 16'h4010, 32'h10);
    wr32("cmp2_hi", 16'h4014, 32'h0);
    wr32("mtime_lo_max", 16'hBFF8, 32'hFFFF_FFFF);
    wr32("mtime_hi_max", 16'hBFFC, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check_eq("mtip_at_max", 64'(mtip), 64'h1FF);
    tick(4);
    @(posedge clk);
    #1;
    check_eq("mtip_after_wrap", 64'(mtip), 64'h002);
    rd32("mtime_lo_wrap", 16'hBFF8, 32'h0);
    rd32("mtime_hi_wrap", 16'hBFFC, 32'h0);

    // Write and increment in the same cycle: write wins, merge with pre-increment value.
    tick(3);
    bus("tick_write", 1'b1, 16'hBFF8, 32'h0000_AA00, 4'b0010, 32'h0, 1'b0, 1'b1);
    rd32("mtime_merge", 16'hBFF8, 32'h0000_AA00);
    rd32("mtime_merge_hi", 16'hBFFC, 32'h0);
    tick(4);
    rd32("mtime_inc", 16'hBFF8, 32'h0000_AA01);

    // 32-bit halves of mtimecmp and byte strobes.
    wr32("cmp0_hi1", 16'h4004, 32'h1);
    wr32("cmp0_lo0", 16'h4000, 32'h0);
    rd32("cmp0_lo_rd", 16'h4000, 32'h0);
    rd32("cmp0_hi_rd", 16'h4004, 32'h1);
    bus("cmp0_strb", 1'b1, 16'h4000, 32'hDEAD_BEEF, 4'b0001, 32'h0, 1'b0, 1'b0);
    rd32("cmp0_strb_lo", 16'h4000, 32'h0000_00EF);
    rd32("cmp0_strb_hi", 16'h4004, 32'h1);

    // Unmapped and misaligned accesses.
    rd_err("cmp_misaligned", 16'h4002);
    bus("wr_misaligned", 1'b1, 16'h4002, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b0);
    rd32("cmp0_unchanged", 16'h4000, 32'h0000_00EF);
    rd_err("msip_misaligned", 16'h000D);
    rd_err("cmp9_unmapped", 16'h4048);
    rd_err("msip9_unmapped", 16'h0024);
    bus("wr_unmapped", 1'b1, 16'hBFF0, 32'h1, 4'hF, 32'h0, 1'b1, 1'b0);
    rd32("mtime_unchanged", 16'hBFF8, 32'h0000_AA01);

    // Stalled error response stays stable and blocks new requests.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rd_err("stall_rsp", 16'h2000);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0000;
    req_wdata = 32'h1;
    req_strb  = 4'hF;
    for (int k = 0; k < 3; k++) begin
      check_eq("stall_valid", 64'(rsp_valid), 64'd1);
      check_eq("stall_error", 64'(rsp_err), 64'd1);
      check_eq("stall_rdata", 64'(rsp_rdata), 64'd0);
      check_eq("stall_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check_eq("stall_no_write", 64'(msip), 64'h000);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("stall_released", 64'(rsp_valid), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
